// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Shared ALU opcode type and pipeline constants
package alu_pkg;

  typedef enum logic [2:0] {
    AND = 3'd0,
    OR  = 3'd1,
    NOT = 3'd2,
    ADD = 3'd3,
    SUB = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6
  } alu_op_t;

  localparam int ALU_LAT        = 2;
  localparam int ALU_RESP_DEPTH = 8;

endpackage

// File: rtl/alu_resp_buffer_if.sv
// rtl/alu_resp_buffer_if.sv - Issue credit, ALU result and consumer handshake bundle
interface alu_resp_buffer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = ALU_RESP_DEPTH
) ();

  logic                       alu_issue_i;
  logic                       issue_ok_o;
  logic                       res_valid_i;
  logic [WIDTH-1:0]           res_i;
  logic                       out_valid_o;
  logic [WIDTH-1:0]           out_data_o;
  logic                       out_ready_i;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic                       overflow_o;

  // Issuer / ALU / consumer side
  modport master (
    output alu_issue_i, res_valid_i, res_i, out_ready_i,
    input  issue_ok_o, out_valid_o, out_data_o, count_o, overflow_o
  );

  // Response buffer side
  modport slave (
    input  alu_issue_i, res_valid_i, res_i, out_ready_i,
    output issue_ok_o, out_valid_o, out_data_o, count_o, overflow_o
  );

endinterface

// File: rtl/alu_resp_buffer.sv
// rtl/alu_resp_buffer.sv - Result FIFO with issue credit behind the ALU; optional same-cycle bypass via ALU_RESP_BYPASS_EN
module alu_resp_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = ALU_RESP_DEPTH,
  parameter int WIDTH = 32,
  parameter int LAT   = ALU_LAT
) (
  input logic              clk,
  input logic              rst,
  alu_resp_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  // The ALU pipeline can never hold more than LAT ops, so inflight stays small.
  localparam int IW = $clog2(LAT + 2);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [IW-1:0]    inflight;
  logic             overflow;

  logic             empty;
  logic             full;
  logic             bypass;
  logic             pop_mem;
  logic             push_mem;
  logic             wr_en;
  logic [SW-1:0]    load;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef ALU_RESP_BYPASS_EN
  assign bypass          = empty & bus.res_valid_i;
  assign bus.out_data_o  = empty ? bus.res_i : mem[rd_ptr];
`else
  assign bypass          = 1'b0;
  assign bus.out_data_o  = mem[rd_ptr];
`endif

  assign bus.out_valid_o = !empty | bypass;

  // A bypassed result taken by the consumer never touches storage.
  assign pop_mem  = !empty & bus.out_ready_i;
  assign push_mem = bus.res_valid_i & !(bypass & bus.out_ready_i);
  // When full, a push only lands if a pop frees the head slot in the same cycle.
  assign wr_en    = push_mem & (!full | pop_mem);

  // Credit covers both stored results and results still inside the ALU.
  assign load           = SW'(count) + SW'(inflight);
  assign bus.issue_ok_o = load < SW'(DEPTH);
  assign bus.count_o    = count;
  assign bus.overflow_o = overflow;

  // Result storage write; contents need no reset since out_valid_o gates them.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= bus.res_i;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !pop_mem) begin
        count <= count + CW'(1);
      end else if (pop_mem && !wr_en) begin
        count <= count - CW'(1);
      end
      if (push_mem && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  // Ops launched into the ALU whose result has not yet come back.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({bus.alu_issue_i, bus.res_valid_i})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // A result with nothing outstanding means the ALU and this block disagree.
  assert property (@(posedge clk) disable iff (rst)
    !(bus.res_valid_i && !bus.alu_issue_i && inflight == '0));

endmodule

// File: tb/tb_alu_resp_buffer.sv
// tb/tb_alu_resp_buffer.sv - Randomized self-checking bench for alu_resp_buffer against a queue model
module tb_alu_resp_buffer;
  import alu_pkg::*;

  localparam int DEPTH = ALU_RESP_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_resp_buffer_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

  alu_resp_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored results, ops in flight, sticky overflow, ALU latency line.
  logic [31:0] q[$];
  int          infl;
  bit          ovf;
  bit          pv [ALU_LAT];
  logic [31:0] pf [ALU_LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_f(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      AND:     return a & b;
      OR:      return a | b;
      NOT:     return ~a;
      ADD:     return a + b;
      SUB:     return a - b;
      SHL:     return a << b[4:0];
      SHR:     return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic bit credit_ok();
    return (q.size() + infl) < DEPTH;
  endfunction

  // One clock: drive at negedge, check combinational view, advance model at posedge.
  task automatic step(input bit iss, input logic [31:0] f, input bit rdy);
    bit          push;
    bit          pop;
    bit          exp_valid;
    logic [31:0] exp_data;
    bus.alu_issue_i = iss;
    bus.res_valid_i = pv[ALU_LAT-1];
    bus.res_i       = pf[ALU_LAT-1];
    bus.out_ready_i = rdy;
    push      = pv[ALU_LAT-1];
    exp_valid = q.size() != 0;
    exp_data  = (q.size() != 0) ? q[0] : 32'h0;
`ifdef ALU_RESP_BYPASS_EN
    if (q.size() == 0 && push) begin
      exp_valid = 1'b1;
      exp_data  = pf[ALU_LAT-1];
    end
`endif
    #1;
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
      check("count", 32'(bus.count_o), 32'(q.size()));
      check("issue_ok", 32'(bus.issue_ok_o), 32'(credit_ok()));
      check("overflow", 32'(bus.overflow_o), 32'(ovf));
      if (exp_valid) check("out_data", bus.out_data_o, exp_data);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      infl = 0;
      ovf  = 1'b0;
    end else begin
      pop = (q.size() != 0) && rdy;
`ifdef ALU_RESP_BYPASS_EN
      if (q.size() == 0 && push && rdy) push = 1'b0;
`endif
      if (push && q.size() == DEPTH && !pop) begin
        ovf = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(pf[ALU_LAT-1]);
      end
      if (iss) infl++;
      if (pv[ALU_LAT-1] && infl > 0) infl--;
    end
    for (int i = ALU_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pf[i] = pf[i-1];
    end
    pv[0] = iss;
    pf[0] = f;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 20; i++) begin
      if (credit_ok()) step(1'b1, $urandom, 1'b0);
      else step(1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    alu_op_t op;
    rst             = 1'b1;
    bus.alu_issue_i = 1'b0;
    bus.res_valid_i = 1'b0;
    bus.res_i       = '0;
    bus.out_ready_i = 1'b0;
    infl            = 0;
    ovf             = 1'b0;
    for (int i = 0; i < ALU_LAT; i++) begin
      pv[i] = 1'b0;
      pf[i] = '0;
    end
    @(negedge clk);

    // Reset state
    do_reset(3);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_issue_ok", 32'(bus.issue_ok_o), 32'd1);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);

    // Streaming: ADD 5+7 then SUB 9-3
    step(1'b1, alu_f(ADD, 32'd5, 32'd7), 1'b1);
    step(1'b1, alu_f(SUB, 32'd9, 32'd3), 1'b1);
    step(1'b0, 32'h0, 1'b1);
`ifndef ALU_RESP_BYPASS_EN
    check("stream_first_valid", 32'(bus.out_valid_o), 32'd1);
    check("stream_first_data", bus.out_data_o, 32'd12);
    step(1'b0, 32'h0, 1'b1);
    check("stream_second_data", bus.out_data_o, 32'd6);
`else
    step(1'b0, 32'h0, 1'b1);
`endif
    step(1'b0, 32'h0, 1'b1);
    check("stream_drained", 32'(bus.out_valid_o), 32'd0);

    // Fill until credit runs out
    fill();
    check("fill_count", 32'(bus.count_o), 32'(DEPTH));
    check("fill_issue_ok", 32'(bus.issue_ok_o), 32'd0);
    check("fill_overflow", 32'(bus.overflow_o), 32'd0);

    // Overflow: an issue made without credit returns 32'hDEAD into a full FIFO
    step(1'b1, alu_f(ADD, 32'hDEAD, 32'h0), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    check("ovf_sticky", 32'(bus.overflow_o), 32'd1);
    check("ovf_count", 32'(bus.count_o), 32'(DEPTH));

    // Full push + pop in the same cycle, then drain through the wrap
    do_reset(3);
    check("ovf_cleared", 32'(bus.overflow_o), 32'd0);
    fill();
    step(1'b1, alu_f(SHL, 32'h3, 32'h4), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("pushpop_count", 32'(bus.count_o), 32'(DEPTH));
    check("pushpop_overflow", 32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    check("pushpop_drained", 32'(bus.count_o), 32'd0);

    // Random traffic within credit
    for (int i = 0; i < 400; i++) begin
      op = alu_op_t'($urandom_range(0, 6));
      if (credit_ok() && $urandom_range(0, 3) != 0)
        step(1'b1, alu_f(op, $urandom, $urandom), 1'($urandom_range(0, 1)));
      else
        step(1'b0, 32'h0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);

    // Mid-operation reset with 5 stored and 2 in flight
    do_reset(3);
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0);
    check("mid_count_before", 32'(bus.count_o), 32'd5);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    check("mid_count", 32'(bus.count_o), 32'd0);
    check("mid_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_issue_ok", 32'(bus.issue_ok_o), 32'd1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    check("mid_stale_dropped", 32'(bus.count_o), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
